// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing blocks.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sc_sng_state_t;

    // x^8 + x^4 + x^3 + x^2 + 1, taps taken from a left-shifting Fibonacci register
    localparam logic [7:0] SC_TAPS8 = 8'b1000_1110;

    function automatic int unsigned sc_len(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR that shifts left and feeds the parity of the tapped bits into bit 0.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = SC_TAPS8,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic feedback;

    assign feedback = ^(q & TAPS);

    // Load wins over en so a new stream always restarts from SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: turns a WIDTH-bit operand into a 2^WIDTH-1 bit unipolar
// bitstream by comparing it against an LFSR, delivered over a valid/ready stream.
module sc_sng
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = SC_TAPS8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             last,
    output logic [WIDTH-1:0] ones
);

    localparam int unsigned    L        = sc_len(WIDTH);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(L - 1);
    localparam logic [WIDTH-1:0] ONES_MAX = WIDTH'(L - 1);

    if (SEED == '0) begin : g_bad_seed
        $error("sc_sng: SEED must be non-zero");
    end

    sc_sng_state_t    state;
    sc_sng_state_t    state_next;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lfsr_q;
    logic             accept;
    logic             gen;
    logic             xfer;

    assign ready  = (state == IDLE);
    assign accept = start && ready;
    assign xfer   = bit_valid && bit_ready;
    assign gen    = (state == RUN) && (!bit_valid || bit_ready);

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (gen),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (gen && (cnt == CNT_LAST)) state_next = DRAIN;
            DRAIN:   if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register refills on the same edge it is consumed, so a held-high
    // bit_ready sees one bit per cycle with no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            ones      <= '0;
        end else if (accept) begin
            value_q <= value;
            cnt     <= '0;
            ones    <= '0;
        end else begin
            if (xfer && bit_out && (ones != ONES_MAX)) begin
                ones <= ones + WIDTH'(1);
            end
            if (gen) begin
                bit_out   <= (value_q > lfsr_q);
                bit_valid <= 1'b1;
                last      <= (cnt == CNT_LAST);
                cnt       <= cnt + WIDTH'(1);
            end else if ((state == DRAIN) && xfer) begin
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                last      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sc_sng.sv
// Self-checking bench for sc_sng: two instances (SEED 1 and 244) checked every cycle
// against a stream model built from the LFSR recurrence and the operand compare rule.
module tb_sc_sng;
    import sc_pkg::*;

    localparam int W = 8;
    localparam int L = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_ready = 1'b1;
    logic [1:0]   start_v = '0;
    logic [1:0]   ready_v;
    logic [1:0]   bv_v;
    logic [1:0]   bo_v;
    logic [1:0]   last_v;
    logic [W-1:0] value_v [2];
    logic [W-1:0] ones_v [2];

    int n_checks = 0;
    int n_errors = 0;

    int seq [2][L];
    bit active [2];
    bit first [2];
    int idx [2];
    int exp_ones [2];
    int xfers [2];
    int lasts [2];
    int val_q [2];
    int first_bit [2];
    bit dual_mode = 1'b0;
    int and_dut = 0;
    int and_exp = 0;

    always #5 clk = ~clk;

    sc_sng #(.WIDTH(W), .SEED(8'd1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[0]),
        .value     (value_v[0]),
        .ready     (ready_v[0]),
        .bit_out   (bo_v[0]),
        .bit_valid (bv_v[0]),
        .bit_ready (bit_ready),
        .last      (last_v[0]),
        .ones      (ones_v[0])
    );

    sc_sng #(.WIDTH(W), .SEED(8'd244)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[1]),
        .value     (value_v[1]),
        .ready     (ready_v[1]),
        .bit_out   (bo_v[1]),
        .bit_valid (bv_v[1]),
        .bit_ready (bit_ready),
        .last      (last_v[1]),
        .ones      (ones_v[1])
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void build_seq(input int inst, input logic [7:0] seed);
        logic [7:0] s;
        s = seed;
        for (int k = 0; k < L; k++) begin
            seq[inst][k] = int'(s);
            s = {s[6:0], ^(s & 8'h8E)};
        end
    endfunction

    function automatic int exp_bit(input int inst);
        if (idx[inst] >= L) return 0;
        return (val_q[inst] > seq[inst][idx[inst]]) ? 1 : 0;
    endfunction

    // Model state advances at the falling edge to describe the next rising edge.
    always @(negedge clk) begin
        if (dual_mode && rst_n) begin
            check_output("align_valid", bv_v[0], bv_v[1]);
            check_output("align_last", last_v[0], last_v[1]);
            if (bv_v[0] && bv_v[1] && bit_ready) begin
                and_dut += int'(bo_v[0] & bo_v[1]);
                and_exp += exp_bit(0) & exp_bit(1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check_output($sformatf("rst_ready%0d", i), ready_v[i], 1);
                check_output($sformatf("rst_valid%0d", i), bv_v[i], 0);
                check_output($sformatf("rst_last%0d", i), last_v[i], 0);
                check_output($sformatf("rst_ones%0d", i), ones_v[i], 0);
                active[i] = 0; first[i] = 0; idx[i] = 0;
                exp_ones[i] = 0; xfers[i] = 0; lasts[i] = 0;
            end else begin
                check_output($sformatf("ready%0d", i), ready_v[i], !active[i]);
                check_output($sformatf("valid%0d", i), bv_v[i], active[i] && !first[i]);
                if (active[i] && !first[i]) begin
                    check_output($sformatf("bit%0d_%0d", i, idx[i]), bo_v[i], exp_bit(i));
                    check_output($sformatf("last%0d_%0d", i, idx[i]), last_v[i], idx[i] == L - 1);
                end
                check_output($sformatf("ones%0d", i), ones_v[i], exp_ones[i]);
                if (active[i]) begin
                    if (first[i]) begin
                        first[i] = 0;
                    end else if (bit_ready) begin
                        exp_ones[i] += exp_bit(i);
                        if (xfers[i] == 0) first_bit[i] = int'(bo_v[i]);
                        xfers[i]++;
                        lasts[i] += int'(last_v[i]);
                        if (idx[i] == L - 1) active[i] = 0;
                        idx[i]++;
                    end
                end else if (start_v[i]) begin
                    active[i] = 1; first[i] = 1; idx[i] = 0;
                    exp_ones[i] = 0; xfers[i] = 0; lasts[i] = 0;
                    val_q[i] = int'(value_v[i]);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] which, input int va, input int vb);
        @(posedge clk); #1;
        value_v[0] = W'(va);
        value_v[1] = W'(vb);
        start_v = which;
        @(posedge clk); #1;
        start_v = '0;
        value_v[0] = ~W'(va);
        value_v[1] = ~W'(vb);
    endtask

    task automatic wait_idle(input bit rnd, input int inject_at, input int inject_val, output int cycles);
        int c;
        for (c = 0; c < 3000; c++) begin
            if (!active[0] && !active[1]) break;
            bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_v[1] = 1'b0;
            start_v[0] = (c == inject_at);
            if (c == inject_at) value_v[0] = W'(inject_val);
            @(posedge clk); #1;
        end
        start_v = '0;
        bit_ready = 1'b1;
        cycles = c;
        if (active[0] || active[1]) check_output("stream_timeout", 1, 0);
    endtask

    task automatic single_stream(input string name, input int v, input bit rnd, input int ones_exp);
        int cyc;
        apply_stimulus(2'b01, v, 0);
        wait_idle(rnd, -1, 0, cyc);
        check_output({name, "_xfers"}, xfers[0], L);
        check_output({name, "_lasts"}, lasts[0], 1);
        check_output({name, "_ones"}, ones_v[0], ones_exp);
    endtask

    initial begin
        int cyc;
        int seen;
        bit hit [256];
        value_v[0] = '0;
        value_v[1] = '0;
        build_seq(0, 8'd1);
        build_seq(1, 8'd244);

        check_output("model_seq1", seq[0][1], 2);
        check_output("model_seq2", seq[0][2], 5);
        for (int i = 0; i < 2; i++) begin
            foreach (hit[k]) hit[k] = 0;
            seen = 0;
            for (int k = 0; k < L; k++) begin
                if (seq[i][k] != 0 && !hit[seq[i][k]]) seen++;
                hit[seq[i][k]] = 1;
            end
            check_output($sformatf("model_perm%0d", i), seen, L);
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", ready_v[0], 1);
        check_output("reset_bit_out", bo_v[0], 0);
        rst_n = 1'b1;

        apply_stimulus(2'b01, 128, 0);
        wait_idle(1'b0, -1, 0, cyc);
        check_output("v128_cycles", cyc, 256);
        check_output("v128_xfers", xfers[0], L);
        check_output("v128_lasts", lasts[0], 1);
        check_output("v128_ones", ones_v[0], 127);
        check_output("v128_ready", ready_v[0], 1);

        single_stream("v0", 0, 1'b0, 0);
        single_stream("v255", 255, 1'b0, 254);
        single_stream("v2", 2, 1'b0, 1);
        check_output("v2_first_bit", first_bit[0], 1);
        single_stream("v200_rnd", 200, 1'b1, 199);

        dual_mode = 1'b1;
        apply_stimulus(2'b11, 224, 239);
        wait_idle(1'b1, -1, 0, cyc);
        dual_mode = 1'b0;
        check_output("dual_ones_a", ones_v[0], 223);
        check_output("dual_ones_b", ones_v[1], 238);
        check_output("dual_xfers_a", xfers[0], L);
        check_output("dual_xfers_b", xfers[1], L);
        check_output("dual_and", and_dut, and_exp);
        $display("[TB] AND-ed product ones = %0d", and_dut);

        apply_stimulus(2'b01, 100, 0);
        wait_idle(1'b0, 20, 30, cyc);
        check_output("restart_ignored_ones", ones_v[0], 99);

        apply_stimulus(2'b01, 150, 0);
        for (int c = 0; c < 400 && idx[0] < 100; c++) begin
            @(posedge clk); #1;
        end
        check_output("abort_reached", idx[0], 100);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_ready", ready_v[0], 1);
        check_output("abort_valid", bv_v[0], 0);
        check_output("abort_last", last_v[0], 0);
        check_output("abort_ones", ones_v[0], 0);
        check_output("abort_bit_out", bo_v[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        single_stream("after_abort", 150, 1'b0, 149);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
